// File: rtl/spi_fb_pkg.sv
// Shared command codes, FSM encoding and status-bit layout for the SPI frame-buffer target.
package spi_fb_pkg;

    localparam logic [7:0] CMD_WRITE_ROW  = 8'h01;
    localparam logic [7:0] CMD_FRAME_SWAP = 8'h02;
    localparam logic [7:0] CMD_STATUS     = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ROWADDR = 3'd2,
        ST_PIX     = 3'd3,
        ST_DONE    = 3'd4,
        ST_STATUS  = 3'd5,
        ST_IGNORE  = 3'd6
    } state_t;

    localparam int STAT_FRAME_PEND = 0;
    localparam int STAT_ROW_PEND   = 1;
    localparam int STAT_OVERRUN    = 2;

    // Address width that stays at least one bit wide for degenerate sizes.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_target_phy.sv
// SPI mode-0 target front end: oversampled synchronizers, edge detect,
// byte-wide receive shifter and a status transmit shifter.
module spi_target_phy (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic       byte_stb,
    output logic [7:0] rx_byte,
    output logic       cs_active,
    output logic       tx_bit
);

    logic [1:0] sck_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sck_prev;
    logic       sck_rise;
    logic       sck_fall;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_hold;
    logic       tx_armed;
    logic [7:0] tx_shift;

    // Chip select resets to the inactive level so nothing starts out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_sck};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sck_prev  <= sck_sync[1];
        end
    end

    assign sck_rise  = sck_sync[1] & ~sck_prev;
    assign sck_fall  = ~sck_sync[1] & sck_prev;
    assign cs_active = ~cs_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
            rx_byte  <= 8'd0;
            byte_stb <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            if (!cs_active) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                rx_shift <= {rx_shift[5:0], mosi_sync[1]};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_byte  <= {rx_shift, mosi_sync[1]};
                    byte_stb <= 1'b1;
                end
            end
        end
    end

    // A load is parked until the next SCK fall so bit 7 appears on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_hold  <= 8'd0;
            tx_armed <= 1'b0;
            tx_shift <= 8'd0;
        end else if (!cs_active) begin
            tx_armed <= 1'b0;
            tx_shift <= 8'd0;
        end else if (sck_fall) begin
            if (tx_load) begin
                tx_shift <= tx_byte;
            end else if (tx_armed) begin
                tx_shift <= tx_hold;
            end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
            tx_armed <= 1'b0;
        end else if (tx_load) begin
            tx_hold  <= tx_byte;
            tx_armed <= 1'b1;
        end
    end

    assign tx_bit = tx_shift[7];

endmodule

// File: rtl/spi_fb_target.sv
// SPI target that decodes row-write, frame-swap and status commands and
// drives the hub75 frame-buffer write port.
module spi_fb_target
    import spi_fb_pkg::*;
#(
    parameter int N_BANKS  = 2,
    parameter int N_ROWS   = 32,
    parameter int N_COLS   = 64,
    parameter int N_CHANS  = 3,
    parameter int N_PLANES = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          spi_sck,
    input  logic                          spi_cs_n,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    output logic [addr_w(N_BANKS)-1:0]    fbw_bank_addr,
    output logic [addr_w(N_ROWS)-1:0]     fbw_row_addr,
    output logic                          fbw_row_store,
    input  logic                          fbw_row_rdy,
    output logic                          fbw_row_swap,
    output logic [N_CHANS*N_PLANES-1:0]   fbw_data,
    output logic [addr_w(N_COLS)-1:0]     fbw_col_addr,
    output logic                          fbw_wren,
    output logic                          frame_swap,
    input  logic                          frame_rdy
);

    localparam int BANK_W = addr_w(N_BANKS);
    localparam int ROW_W  = addr_w(N_ROWS);
    localparam int COL_W  = addr_w(N_COLS);

    state_t             state;
    state_t             state_nxt;
    logic               byte_stb;
    logic [7:0]         rx_byte;
    logic               cs_active;
    logic               tx_bit;
    logic               tx_load;
    logic [7:0]         tx_byte;
    logic [1:0]         chan;
    logic [COL_W-1:0]   col;
    logic [7:0]         r_byte;
    logic [7:0]         g_byte;
    logic               row_pend;
    logic               frame_pend;
    logic               overrun;
    logic               last_pix;
    logic               load_row;
    logic               pix_byte;
    logic               pix_write;
    logic               row_done;
    logic               set_overrun;
    logic               clr_overrun;
    logic               set_frame;

    spi_target_phy u_phy (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sck   (spi_sck),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .tx_load   (tx_load),
        .tx_byte   (tx_byte),
        .byte_stb  (byte_stb),
        .rx_byte   (rx_byte),
        .cs_active (cs_active),
        .tx_bit    (tx_bit)
    );

    assign tx_byte  = {5'b0, overrun, row_pend, frame_pend};
    assign last_pix = (chan == 2'd2) && (col == COL_W'(N_COLS - 1));
    assign spi_miso = (state == ST_STATUS) && tx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Deasserted chip select always wins and drops any transfer in progress.
    always_comb begin
        state_nxt = state;
        if (!cs_active) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_CMD;
                ST_CMD: begin
                    if (byte_stb) begin
                        if (rx_byte == CMD_WRITE_ROW) begin
                            state_nxt = row_pend ? ST_IGNORE : ST_ROWADDR;
                        end else if (rx_byte == CMD_STATUS) begin
                            state_nxt = ST_STATUS;
                        end else begin
                            state_nxt = ST_IGNORE;
                        end
                    end
                end
                ST_ROWADDR: if (byte_stb) state_nxt = ST_PIX;
                ST_PIX:     if (byte_stb && last_pix) state_nxt = ST_DONE;
                default:    state_nxt = state;
            endcase
        end
    end

    always_comb begin
        load_row    = 1'b0;
        pix_byte    = 1'b0;
        pix_write   = 1'b0;
        row_done    = 1'b0;
        set_overrun = 1'b0;
        clr_overrun = 1'b0;
        set_frame   = 1'b0;
        tx_load     = 1'b0;
        if (cs_active && byte_stb) begin
            case (state)
                ST_CMD: begin
                    set_overrun = (rx_byte == CMD_WRITE_ROW) && row_pend;
                    set_frame   = (rx_byte == CMD_FRAME_SWAP);
                    tx_load     = (rx_byte == CMD_STATUS);
                end
                ST_ROWADDR: load_row = 1'b1;
                ST_PIX: begin
                    pix_byte  = 1'b1;
                    pix_write = (chan == 2'd2);
                    row_done  = last_pix;
                end
                ST_STATUS: clr_overrun = 1'b1;
                default: ;
            endcase
        end
    end

    // Strobes are registered one clock behind the byte that caused them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fbw_bank_addr <= '0;
            fbw_row_addr  <= '0;
            fbw_row_store <= 1'b0;
            fbw_row_swap  <= 1'b0;
            fbw_data      <= '0;
            fbw_col_addr  <= '0;
            fbw_wren      <= 1'b0;
            frame_swap    <= 1'b0;
            chan          <= 2'd0;
            col           <= '0;
            r_byte        <= 8'd0;
            g_byte        <= 8'd0;
            row_pend      <= 1'b0;
            frame_pend    <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            fbw_wren      <= pix_write;
            fbw_row_store <= row_pend && fbw_row_rdy;
            fbw_row_swap  <= row_pend && fbw_row_rdy;
            frame_swap    <= frame_pend && frame_rdy;

            if (load_row) begin
                fbw_row_addr  <= rx_byte[ROW_W-1:0];
                fbw_bank_addr <= rx_byte[ROW_W +: BANK_W];
                chan          <= 2'd0;
                col           <= '0;
            end

            if (pix_byte) begin
                case (chan)
                    2'd0:    r_byte <= rx_byte;
                    2'd1:    g_byte <= rx_byte;
                    default: ;
                endcase
                if (chan == 2'd2) begin
                    chan         <= 2'd0;
                    fbw_data     <= {rx_byte[7 -: N_PLANES], g_byte[7 -: N_PLANES],
                                     r_byte[7 -: N_PLANES]};
                    fbw_col_addr <= col;
                    col          <= col + COL_W'(1);
                end else begin
                    chan <= chan + 2'd1;
                end
            end

            if (row_pend && fbw_row_rdy) row_pend <= 1'b0;
            if (row_done)                row_pend <= 1'b1;

            // A new request arriving with the pulse is kept rather than lost.
            if (frame_pend && frame_rdy) frame_pend <= 1'b0;
            if (set_frame)               frame_pend <= 1'b1;

            if (clr_overrun) overrun <= 1'b0;
            if (set_overrun) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_fb_target.sv
// Scoreboard bench for spi_fb_target: SPI host model drives commands, a
// monitor checks every frame-buffer write, row commit and frame swap.
module tb_spi_fb_target;

    typedef struct packed {
        logic [5:0]  col;
        logic [23:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [0:0]  fbw_bank_addr;
    logic [4:0]  fbw_row_addr;
    logic        fbw_row_store;
    logic        fbw_row_rdy;
    logic        fbw_row_swap;
    logic [23:0] fbw_data;
    logic [5:0]  fbw_col_addr;
    logic        fbw_wren;
    logic        frame_swap;
    logic        frame_rdy;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   half     = 4;
    wr_t  exp_wr[$];
    logic [5:0] exp_commit[$];
    bit   exp_frame[$];

    spi_fb_target dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi_sck       (spi_sck),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .fbw_bank_addr (fbw_bank_addr),
        .fbw_row_addr  (fbw_row_addr),
        .fbw_row_store (fbw_row_store),
        .fbw_row_rdy   (fbw_row_rdy),
        .fbw_row_swap  (fbw_row_swap),
        .fbw_data      (fbw_data),
        .fbw_col_addr  (fbw_col_addr),
        .fbw_wren      (fbw_wren),
        .frame_swap    (frame_swap),
        .frame_rdy     (frame_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic unexpected(input string name, input logic [63:0] got);
        n_checks++;
        $display("[TB] FAIL %s: unexpected pulse, got %0h, expected none", name, got);
    endtask

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            repeat (half) @(negedge clk);
            rx[i]   = spi_miso;
            spi_sck = 1'b1;
            repeat (half) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        spi_sck  = 1'b0;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (8) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // WRITE_ROW with n_pix full pixels k=(R=k,G=0x80,B=0xFF-k) then n_extra loose bytes.
    task automatic applyStimulus(input logic [7:0] row, input int n_pix, input int n_extra,
                                 input bit expect_wr, input bit keep_cs);
        logic [7:0] rx;
        wr_t        e;
        cs_begin();
        spi_xfer(8'h01, rx);
        spi_xfer(row, rx);
        for (int k = 0; k < n_pix; k++) begin
            if (expect_wr) begin
                e.col  = 6'(k);
                e.data = {8'(8'hFF - k), 8'h80, 8'(k)};
                exp_wr.push_back(e);
            end
            spi_xfer(8'(k), rx);
            spi_xfer(8'h80, rx);
            spi_xfer(8'(8'hFF - k), rx);
        end
        for (int j = 0; j < n_extra; j++) spi_xfer(8'h11, rx);
        if (!keep_cs) cs_end();
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input int n_extra);
        logic [7:0] rx;
        cs_begin();
        spi_xfer(cmd, rx);
        for (int j = 0; j < n_extra; j++) spi_xfer(8'h5A, rx);
        cs_end();
    endtask

    task automatic read_status(input string name, input logic [7:0] expected);
        logic [7:0] rx;
        logic [7:0] got;
        cs_begin();
        spi_xfer(8'h03, rx);
        spi_xfer(8'h00, got);
        cs_end();
        checkOutput(name, got, expected);
    endtask

    // Monitor: every strobe the DUT presents must match the head of its queue.
    always @(negedge clk) begin : monitor
        wr_t        e;
        logic [5:0] rc;
        if (rst_n) begin
            if (fbw_wren) begin
                if (exp_wr.size() == 0) begin
                    unexpected("wren", {fbw_col_addr, fbw_data});
                end else begin
                    e = exp_wr.pop_front();
                    checkOutput("wren_col", fbw_col_addr, e.col);
                    checkOutput("wren_data", fbw_data, e.data);
                end
            end
            if (fbw_row_store || fbw_row_swap) begin
                checkOutput("row_swap_with_store", fbw_row_swap, fbw_row_store);
                if (exp_commit.size() == 0) begin
                    unexpected("row_commit", {fbw_bank_addr, fbw_row_addr});
                end else begin
                    rc = exp_commit.pop_front();
                    checkOutput("commit_addr", {fbw_bank_addr, fbw_row_addr}, rc);
                end
            end
            if (frame_swap) begin
                if (exp_frame.size() == 0) unexpected("frame_swap", frame_swap);
                else void'(exp_frame.pop_front());
            end
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("[TB] FAIL watchdog: got no finish after 150000 cycles, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        spi_sck     = 1'b0;
        spi_cs_n    = 1'b1;
        spi_mosi    = 1'b0;
        fbw_row_rdy = 1'b1;
        frame_rdy   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {spi_miso, fbw_bank_addr, fbw_row_addr, fbw_row_store,
                    fbw_row_swap, fbw_data, fbw_col_addr, fbw_wren, frame_swap}, 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] full row to 0x21 with row ready");
        exp_commit.push_back(6'h21);
        applyStimulus(8'h21, 64, 0, 1'b1, 1'b0);

        $display("[TB] two frame swaps merged");
        send_cmd(8'h02, 0);
        send_cmd(8'h02, 2);
        read_status("status_frame_pend", 8'h01);
        exp_frame.push_back(1'b1);
        frame_rdy = 1'b1;
        @(negedge clk);
        checkOutput("frame_swap_latency", frame_swap, 1'b1);
        repeat (20) @(negedge clk);
        read_status("status_after_swap", 8'h00);

        $display("[TB] row aborted by chip select after 10 pixels");
        applyStimulus(8'h21, 10, 2, 1'b1, 1'b0);

        $display("[TB] reset mid-row at sck=clk/4, then full row");
        half = 2;
        applyStimulus(8'h05, 5, 1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("outputs_in_reset", {spi_miso, fbw_bank_addr, fbw_row_addr, fbw_row_store,
                    fbw_row_swap, fbw_data, fbw_col_addr, fbw_wren, frame_swap}, 64'd0);
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_commit.push_back(6'h05);
        applyStimulus(8'h05, 64, 0, 1'b1, 1'b0);
        half = 4;

        $display("[TB] full row to 0x3F held off by row ready, overrun");
        fbw_row_rdy = 1'b0;
        applyStimulus(8'h3F, 64, 0, 1'b1, 1'b0);
        applyStimulus(8'h10, 2, 0, 1'b0, 1'b0);
        read_status("status_overrun_pend", 8'h06);
        applyStimulus(8'h10, 1, 0, 1'b0, 1'b0);
        repeat (500) @(negedge clk);
        exp_commit.push_back(6'h3F);
        fbw_row_rdy = 1'b1;
        @(negedge clk);
        checkOutput("commit_latency", fbw_row_store, 1'b1);
        repeat (5) @(negedge clk);
        read_status("status_overrun", 8'h04);
        read_status("status_cleared", 8'h00);

        repeat (20) @(negedge clk);
        checkOutput("pending_writes", exp_wr.size(), 0);
        checkOutput("pending_commits", exp_commit.size(), 0);
        checkOutput("pending_frames", exp_frame.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
